// File: rtl/shift_reg_pkg.sv
// Shared constants and FSM encoding for the universal shift register and its
// serial-transfer controller.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic OP_TX = 1'b0;
    localparam logic OP_RX = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/shift_reg.sv
// Universal shift register datapath: hold, shift right, shift left, parallel load.
module shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] p_in,
    input  logic             s_in,
    output logic [WIDTH-1:0] out
);

    // NOTE: no reset on the data register; every transfer starts with a LOAD,
    // so its contents before that are don't-care and the reset net stays off it.
    always_ff @(posedge clk) begin
        case (mode)
            MODE_SHR:  out <= {s_in, out[WIDTH-1:1]};
            MODE_SHL:  out <= {out[WIDTH-2:0], s_in};
            MODE_LOAD: out <= p_in;
            default:   out <= out;
        endcase
    end

endmodule

// File: rtl/shift_reg_sys.sv
// Controller plus its shift register, wired as one serial transfer engine.
module shift_reg_sys
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             ser_en,
    output logic             done_valid,
    output logic [WIDTH-1:0] done_data
);

    logic [1:0]       sr_mode;
    logic [WIDTH-1:0] sr_p_in;
    logic             sr_s_in;
    logic [WIDTH-1:0] sr_out;

    shift_reg_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dir    (cmd_dir),
        .cmd_data   (cmd_data),
        .ser_out    (ser_out),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .done_valid (done_valid),
        .done_data  (done_data),
        .sr_mode    (sr_mode),
        .sr_p_in    (sr_p_in),
        .sr_s_in    (sr_s_in),
        .sr_out     (sr_out)
    );

    shift_reg #(.WIDTH(WIDTH)) u_sr (
        .clk  (clk),
        .mode (sr_mode),
        .p_in (sr_p_in),
        .s_in (sr_s_in),
        .out  (sr_out)
    );

endmodule

// File: rtl/shift_reg_ctrl.sv
// Sequencer that runs one shift_reg through complete TX (load + WIDTH shifts out)
// or RX (clear + WIDTH shifts in) transfers, one command at a time.
module shift_reg_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic             cmd_dir,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             ser_en,
    output logic             done_valid,
    output logic [WIDTH-1:0] done_data,
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_p_in,
    output logic             sr_s_in,
    input  logic [WIDTH-1:0] sr_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic             dir;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values no matter how the block is ordered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= OP_TX;
            dir     <= 1'b0;
            sr_p_in <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op      <= cmd_op;
                        dir     <= cmd_dir;
                        // RX loads zeros so the received word starts from a clean register.
                        sr_p_in <= (cmd_op == OP_TX) ? cmd_data : '0;
                    end
                end
                LOAD:    cnt <= '0;
                SHIFT:   cnt <= cnt + CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        sr_mode    = MODE_HOLD;
        ser_en     = 1'b0;
        ser_out    = 1'b0;
        sr_s_in    = 1'b0;
        done_valid = 1'b0;
        done_data  = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) state_nxt = LOAD;
                end
                LOAD: begin
                    sr_mode   = MODE_LOAD;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    sr_mode = dir ? MODE_SHL : MODE_SHR;
                    ser_en  = 1'b1;
                    if (op == OP_TX) ser_out = dir ? sr_out[WIDTH-1] : sr_out[0];
                    else             sr_s_in = ser_in;
                    if (cnt == LAST_CNT) state_nxt = DONE;
                end
                DONE: begin
                    done_valid = 1'b1;
                    done_data  = sr_out;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: a behavioural shift register closes the loop, and
// expected serial streams / words are computed from the transfer rules directly.
module tb_shift_reg_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic         cmd_dir;
    logic [W-1:0] cmd_data;
    logic         ser_out;
    logic         ser_in;
    logic         ser_en;
    logic         done_valid;
    logic [W-1:0] done_data;
    logic [1:0]   sr_mode;
    logic [W-1:0] sr_p_in;
    logic         sr_s_in;
    logic [W-1:0] sr_out;

    int vectors    = 0;
    int miscompares = 0;
    int cycle      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    shift_reg_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_dir    (cmd_dir),
        .cmd_data   (cmd_data),
        .ser_out    (ser_out),
        .ser_in     (ser_in),
        .ser_en     (ser_en),
        .done_valid (done_valid),
        .done_data  (done_data),
        .sr_mode    (sr_mode),
        .sr_p_in    (sr_p_in),
        .sr_s_in    (sr_s_in),
        .sr_out     (sr_out)
    );

    // Environment shift register obeying the datapath contract.
    logic [W-1:0] sr_q = 8'h5A;
    assign sr_out = sr_q;
    always @(posedge clk) begin
        case (sr_mode)
            2'b01:   sr_q <= {sr_s_in, sr_q[W-1:1]};
            2'b10:   sr_q <= {sr_q[W-2:0], sr_s_in};
            2'b11:   sr_q <= sr_p_in;
            default: sr_q <= sr_q;
        endcase
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete transfer; returns the cycle index of its accept edge.
    task automatic run_cmd(input bit op, input bit dir, input logic [W-1:0] data,
                           input logic [W-1:0] rx_bits, input bit hold,
                           input bit n_op, input bit n_dir, input logic [W-1:0] n_data,
                           output int acc);
        int n = 0;
        logic [W-1:0] exp_word;
        acc = -1;
        while (cmd_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles, expected 1", cmd_ready, n);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_data  = data;
        @(negedge clk);
        acc = cycle;
        if (hold) begin
            cmd_op   = n_op;
            cmd_dir  = n_dir;
            cmd_data = n_data;
        end else begin
            cmd_valid = 1'b0;
            cmd_op    = 1'($urandom);
            cmd_dir   = 1'($urandom);
            cmd_data  = W'($urandom);
        end
        cmp("load_mode", sr_mode, 2'b11);
        cmp("load_p_in", sr_p_in, op ? '0 : data);
        cmp("load_ready", cmd_ready, 1'b0);
        exp_word = '0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            ser_in = rx_bits[i];
            #1;
            cmp("shift_en", ser_en, 1'b1);
            cmp("shift_mode", sr_mode, dir ? 2'b10 : 2'b01);
            cmp("shift_ready", cmd_ready, 1'b0);
            cmp("ser_out", ser_out, op ? 1'b0 : (dir ? data[W-1-i] : data[i]));
            cmp("sr_s_in", sr_s_in, op ? rx_bits[i] : 1'b0);
            if (dir) exp_word[W-1-i] = rx_bits[i];
            else     exp_word[i]     = rx_bits[i];
        end
        @(negedge clk);
        ser_in = 1'($urandom);
        #1;
        cmp("done_valid", done_valid, 1'b1);
        cmp("done_data", done_data, op ? exp_word : '0);
        cmp("done_mode", sr_mode, 2'b00);
        cmp("done_en", ser_en, 1'b0);
        cmp("done_ready", cmd_ready, 1'b0);
        @(negedge clk);
        cmp("post_done_valid", done_valid, 1'b0);
        cmp("post_done_ready", cmd_ready, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ser_in = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmp("rst_ready", cmd_ready, 1'b0);
            cmp("rst_mode", sr_mode, 2'b00);
            cmp("rst_en", ser_en, 1'b0);
            cmp("rst_done", done_valid, 1'b0);
            cmp("rst_ser_out", ser_out, 1'b0);
            cmp("rst_s_in", sr_s_in, 1'b0);
            cmp("rst_done_data", done_data, '0);
        end
        cmp("rst_p_in", sr_p_in, '0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        cmp("after_rst_ready", cmd_ready, 1'b1);
        cmp("after_rst_mode", sr_mode, 2'b00);
    endtask

    task automatic test_directed();
        int acc;
        run_cmd(1'b0, 1'b0, 8'hC1, 8'h00, 1'b0, 1'b0, 1'b0, '0, acc);
        run_cmd(1'b0, 1'b1, 8'hC1, 8'h00, 1'b0, 1'b0, 1'b0, '0, acc);
        // ser_in sequence 1,1,0,1,0,0,0,0 is bits [0..7] of 8'h0B.
        run_cmd(1'b1, 1'b0, 8'hFF, 8'h0B, 1'b0, 1'b0, 1'b0, '0, acc);
        run_cmd(1'b1, 1'b1, 8'hFF, 8'h0B, 1'b0, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic test_back_to_back();
        int acc1;
        int acc2;
        logic [W-1:0] rx;
        rx = W'($urandom);
        run_cmd(1'b0, 1'b0, 8'hA7, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, acc1);
        run_cmd(1'b1, 1'b1, 8'h11, rx, 1'b0, 1'b0, 1'b0, '0, acc2);
        cmp("b2b_spacing", acc2 - acc1, W + 3);
        repeat (3) begin
            @(negedge clk);
            cmp("b2b_no_dup", sr_mode, 2'b00);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = 8'hE6;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        cmp("mid_in_shift", ser_en, 1'b1);
        rst = 1'b1;
        #1;
        cmp("mid_rst_en", ser_en, 1'b0);
        cmp("mid_rst_mode", sr_mode, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("mid_idle_ready", cmd_ready, 1'b1);
        cmp("mid_idle_mode", sr_mode, 2'b00);
        cmp("mid_idle_en", ser_en, 1'b0);
        cmp("mid_no_done", done_valid, 1'b0);
        run_cmd(1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic test_random();
        int acc;
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_cmd(1'($urandom), 1'($urandom), W'($urandom), W'($urandom),
                    1'b0, 1'b0, 1'b0, '0, acc);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 1'b0;
        cmd_dir   = 1'b0;
        cmd_data  = '0;
        ser_in    = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_reg_ctrl.md
Name: shift_reg_ctrl

Overview:
Sequencer that drives one universal shift register (WIDTH bits, modes hold/shift-right/shift-left/load) through complete serial transfers. It accepts a command over a valid/ready handshake and performs either a TX (parallel load, then WIDTH shifts out) or an RX (clear, then WIDTH shifts in). On RX completion it returns the assembled word. It sits between a byte-level client and the shift_reg datapath and owns that register's mode, p_in and s_in pins exclusively.

Parameters:
WIDTH, 8, shift register width in bits; must be >= 2.
CNT_W, $clog2(WIDTH+1), localparam, width of the shift counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  controller idle and able to accept a command
cmd_op  in  1  0 = TX (serialize), 1 = RX (deserialize)
cmd_dir  in  1  0 = LSB-first (shift right), 1 = MSB-first (shift left)
cmd_data  in  WIDTH  TX word; ignored for RX
ser_out  out  1  serial TX bit; valid when ser_en = 1 and op = TX
ser_in  in  1  serial RX bit; sampled when ser_en = 1 and op = RX
ser_en  out  1  bit strobe, high for each shift cycle
done_valid  out  1  one-cycle pulse at end of each completed transfer
done_data  out  WIDTH  received word (RX) or residual register value (TX), valid with done_valid
sr_mode  out  2  to shift_reg mode: 00 hold, 01 shift right, 10 shift left, 11 load
sr_p_in  out  WIDTH  to shift_reg p_in
sr_s_in  out  1  to shift_reg s_in
sr_out  in  WIDTH  from shift_reg out

Behaviour:
- Datapath contract:
  - mode 01: out <= {s_in, out[W-1:1]}.
  - mode 10: out <= {out[W-2:0], s_in}.
  - mode 11: out <= p_in.
  - mode 00: hold.
- FSM states: IDLE, LOAD, SHIFT, DONE. State, counter, op, dir and the p_in latch are registered. All outputs are Moore-decoded from the registered state, except sr_s_in and ser_out.
- Reset (rst high at an edge): state = IDLE, cnt = 0, sr_p_in = 0.
- While rst is high:
  - cmd_ready = 0, sr_mode = 00, ser_en = 0, done_valid = 0.
  - ser_out = 0, sr_s_in = 0, done_data = 0.
- IDLE:
  - cmd_ready = 1, sr_mode = 00.
  - Accept occurs when cmd_valid & cmd_ready at an edge. On accept, latch op and dir. Latch sr_p_in = cmd_data for TX, or 0 for RX. Go to LOAD.
- LOAD (1 cycle): sr_mode = 11; cnt <= 0; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - sr_mode = dir ? 10 : 01; ser_en = 1; cnt increments each cycle.
  - Leave for DONE after the cycle in which cnt == WIDTH-1.
- In SHIFT, TX:
  - ser_out = dir ? sr_out[WIDTH-1] : sr_out[0], taken combinationally from sr_out.
  - sr_s_in = 0 (zero fill).
- In SHIFT, RX:
  - sr_s_in = ser_in (combinational pass-through); ser_out = 0.
- Outside SHIFT: sr_s_in = 0 and ser_out = 0.
- DONE (1 cycle): sr_mode = 00; done_valid = 1; done_data = sr_out. Go to IDLE.
- Timing: if the accept edge ends cycle T, then:
  - LOAD is cycle T+1.
  - SHIFT spans cycles T+2 .. T+WIDTH+1.
  - DONE is cycle T+WIDTH+2.
  - cmd_ready is high again at T+WIDTH+3.
  - Minimum command spacing is WIDTH+3 cycles.
- Bit ordering:
  - LOSB-first RX places the first received bit in bit 0.
  - MSB-first RX places the first received bit in bit WIDTH-1.
  - TX emits bit 0 first (dir 0) or bit WIDTH-1 first (dir 1).
- cmd_valid is ignored outside IDLE; no queueing. cmd_data is sampled only at the accept edge.
- Reset mid-transfer: the next cycle is IDLE with hold mode and no done_valid. shift_reg contents are don't-care until the next LOAD.
- ser_in is not sampled outside RX SHIFT cycles.

Decomposition:
- Package shift_reg_pkg holds:
  - mode constants MODE_HOLD = 2'b00, MODE_SHR = 2'b01, MODE_SHL = 2'b10, MODE_LOAD = 2'b11;
  - op constants OP_TX = 1'b0, OP_RX = 1'b1;
  - the FSM state enum (2 bits).
- No sub-module inside the controller; the counter and FSM stay in one module.
- A thin top, shift_reg_sys, instantiates shift_reg_ctrl plus shift_reg and is the verification DUT.

Test Plan:
- Reset: rst high 2 cycles, then low -> during rst: cmd_ready = 0, sr_mode = 00, ser_en = 0, done_valid = 0; first cycle after: cmd_ready = 1.
- TX LSB-first, cmd_data = 8'hC1, dir = 0 -> LOAD cycle with sr_mode = 11 and sr_p_in = C1; then 8 cycles of ser_en = 1 with ser_out = 1,0,0,0,0,0,1,1; done_valid pulse with done_data = 8'h00; cmd_ready low for exactly 10 cycles.
- TX MSB-first, 8'hC1, dir = 1 -> ser_out = 1,1,0,0,0,0,0,1; sr_mode = 10 throughout SHIFT.
- RX, ser_in = 1,1,0,1,0,0,0,0 -> dir = 0 gives done_data = 8'h0B; dir = 1 gives done_data = 8'hD0; done_valid is exactly one cycle wide.
- Back-to-back: cmd_valid held high with a TX then an RX command -> second accept happens in the first IDLE cycle after DONE (11 cycles after the first accept); no command lost or duplicated.
- Reset mid-transfer: rst on the 4th SHIFT cycle of a TX -> next cycle IDLE, sr_mode = 00, ser_en = 0, no done_valid; a following TX of 8'h3C serializes correctly.
